// File: rtl/rf_wb_scoreboard_pkg.sv
// Shared constants for the register-file writeback scoreboard slice.
package rf_wb_scoreboard_pkg;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int NREQ_DEF       = 2;
  localparam int NREG_DEF       = 1 << ADDR_WIDTH_DEF;
  localparam int X0_IDX         = 0;
endpackage

// File: rtl/rf_wb_scoreboard_if.sv
// Issue, writeback-request and register-file write bundle; the master modport drives issue and requests.
interface rf_wb_scoreboard_if
  import rf_wb_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NREQ       = NREQ_DEF
);
  logic                       iss_valid;
  logic [ADDR_WIDTH-1:0]      iss_rs1;
  logic [ADDR_WIDTH-1:0]      iss_rs2;
  logic [ADDR_WIDTH-1:0]      iss_rd;
  logic                       iss_wr;
  logic                       iss_ready;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*ADDR_WIDTH-1:0] req_rd;
  logic [NREQ*DATA_WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       rf_wen;
  logic [ADDR_WIDTH-1:0]      rf_rd;
  logic [DATA_WIDTH-1:0]      rf_dataD;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr, req_valid, req_rd, req_data,
    input  iss_ready, req_ready, rf_wen, rf_rd, rf_dataD
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr, req_valid, req_rd, req_data,
    output iss_ready, req_ready, rf_wen, rf_rd, rf_dataD
  );
endinterface

// File: rtl/rf_wb_scoreboard_rr_arbiter.sv
// Round-robin one-hot arbiter: search starts at the pointer, pointer moves past the winner.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  logic [PTR_W-1:0] ptr;

  always_comb begin : search
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= '0;
    else if (gnt_vld) ptr <= PTR_W'((int'(gnt_idx) + 1) % NREQ);
  end
endmodule

// File: rtl/rf_wb_scoreboard.sv
// Register-file write-port controller: round-robin writeback arbitration plus a
// per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module rf_wb_scoreboard
  import rf_wb_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NREQ       = NREQ_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  rf_wb_scoreboard_if.slave            bus,
  output logic [(1<<ADDR_WIDTH)-1:0]   busy_vec,
  output logic                         err_sticky
);
  localparam int NREG  = 1 << ADDR_WIDTH;
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(X0_IDX);

  logic [NREQ-1:0]       gnt;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  gnt_vld;
  logic [ADDR_WIDTH-1:0] wb_rd_p0;
  logic [DATA_WIDTH-1:0] wb_data_p0;
  logic                  wb_wr_p0;
  logic                  iss_ok;
  logic                  iss_set;
  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_nxt;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] rd_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign bus.req_ready = gnt;
  assign wb_rd_p0      = bus.req_rd[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign wb_data_p0    = bus.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  // Writebacks to x0 complete the handshake but never reach the file.
  assign wb_wr_p0      = gnt_vld && (wb_rd_p0 != X0);

  assign iss_ok  = ~(busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] | (bus.iss_wr & busy_q[bus.iss_rd]));
  assign iss_set = bus.iss_valid & iss_ok & bus.iss_wr & (bus.iss_rd != X0);
  assign bus.iss_ready = iss_ok;

  // Stage p0 -> p1: registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= wb_wr_p0;
      if (wb_wr_p0) begin
        rd_p1   <= wb_rd_p0;
        data_p1 <= wb_data_p0;
      end
    end
  end

  assign bus.rf_wen   = vld_p1;
  assign bus.rf_rd    = rd_p1;
  assign bus.rf_dataD = data_p1;

  // Clear is applied first so a same-edge set keeps the register busy for the new writer.
  always_comb begin
    busy_nxt = busy_q;
    if (vld_p1)  busy_nxt[rd_p1]       = 1'b0;
    if (iss_set) busy_nxt[bus.iss_rd]  = 1'b1;
    busy_nxt[X0_IDX] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      err_sticky <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (wb_wr_p0 && !busy_q[wb_rd_p0]) err_sticky <= 1'b1;
    end
  end

  assign busy_vec = busy_q;
endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Randomized scoreboard bench for rf_wb_scoreboard with directed hazard/arbitration scenarios.
module tb_rf_wb_scoreboard;
  localparam int AW   = 5;
  localparam int DW   = 64;
  localparam int NR   = 2;
  localparam int NREG = 1 << AW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREG-1:0] busy_vec;
  logic            err_sticky;

  rf_wb_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NR)) bus ();

  rf_wb_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .busy_vec   (busy_vec),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model state
  typedef struct { int cyc; logic [AW-1:0] rd; logic [DW-1:0] data; } wr_t;
  wr_t             wq[$];
  logic [NREG-1:0] m_busy;
  logic            m_err;
  int              m_ptr;
  bit              m_wen_v;
  int              m_wen_rd;
  bit              p_valid[NR];
  logic [AW-1:0]   p_rd[NR];
  logic [DW-1:0]   p_data[NR];
  int              s_g;
  bit              s_iss_set;
  bit              s_err;

  function automatic void drive_req();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]         = p_valid[i];
      bus.req_rd[i*AW +: AW]   = p_rd[i];
      bus.req_data[i*DW +: DW] = p_data[i];
    end
  endfunction

  function automatic void set_req(int i, int rd, logic [DW-1:0] data);
    p_valid[i] = 1'b1;
    p_rd[i]    = AW'(rd);
    p_data[i]  = data;
    drive_req();
  endfunction

  function automatic void set_iss(bit v, int rs1, int rs2, int rd, bit wr);
    bus.iss_valid = v;
    bus.iss_rs1   = AW'(rs1);
    bus.iss_rs2   = AW'(rs2);
    bus.iss_rd    = AW'(rd);
    bus.iss_wr    = wr;
  endfunction

  function automatic void model_reset();
    wq.delete();
    m_busy  = '0;
    m_err   = 1'b0;
    m_ptr   = 0;
    m_wen_v = 1'b0;
    m_wen_rd = 0;
    for (int i = 0; i < NR; i++) begin
      p_valid[i] = 1'b0;
      p_rd[i]    = '0;
      p_data[i]  = '0;
    end
    set_iss(1'b0, 0, 0, 0, 1'b0);
    drive_req();
  endfunction

  // Evaluate the rules for the current cycle and compare combinational outputs and state.
  function automatic void eval_cycle();
    bit exp_ready;
    logic [NR-1:0] exp_gnt;
    int rd;
    exp_ready = !(m_busy[bus.iss_rs1] || m_busy[bus.iss_rs2] || (bus.iss_wr && m_busy[bus.iss_rd]));
    s_g = -1;
    for (int k = 0; k < NR; k++)
      if (s_g < 0 && p_valid[(m_ptr + k) % NR]) s_g = (m_ptr + k) % NR;
    exp_gnt = '0;
    if (s_g >= 0) exp_gnt[s_g] = 1'b1;
    chk("iss_ready", bus.iss_ready, exp_ready);
    chk("req_ready", bus.req_ready, exp_gnt);
    chk("busy_vec", busy_vec, m_busy);
    chk("err_sticky", err_sticky, m_err);
    s_iss_set = bus.iss_valid && exp_ready && bus.iss_wr && (bus.iss_rd != 0);
    s_err = 1'b0;
    if (s_g >= 0) begin
      rd = int'(p_rd[s_g]);
      if (rd != 0) begin
        wq.push_back('{cyc: cyc + 1, rd: p_rd[s_g], data: p_data[s_g]});
        s_err = !m_busy[rd];
      end
    end
  endfunction

  function automatic void update_cycle();
    if (m_wen_v) m_busy[m_wen_rd] = 1'b0;
    if (s_iss_set) m_busy[bus.iss_rd] = 1'b1;
    if (s_err) m_err = 1'b1;
    m_wen_v = 1'b0;
    if (s_g >= 0) begin
      m_wen_v    = (p_rd[s_g] != 0);
      m_wen_rd   = int'(p_rd[s_g]);
      m_ptr      = (s_g + 1) % NR;
      p_valid[s_g] = 1'b0;
    end
  endfunction

  task automatic step();
    drive_req();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    update_cycle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rf_wen", bus.rf_wen, 0);
    chk("rst_rf_rd", bus.rf_rd, 0);
    chk("rst_rf_dataD", bus.rf_dataD, 0);
    chk("rst_busy_vec", busy_vec, 0);
    chk("rst_err", err_sticky, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every presented write must match the oldest expected write, on the expected cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rf_wen === 1'b1) begin
        if (wq.size() == 0) chk("rf_wen_unexpected", bus.rf_wen, 0);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("rf_wen_cycle", cyc, e.cyc);
          chk("rf_rd", bus.rf_rd, e.rd);
          chk("rf_dataD", bus.rf_dataD, e.data);
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        chk("rf_wen_missing", bus.rf_wen, 1);
        void'(wq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_list[$];
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // RAW setup: destination 3 goes busy
    set_iss(1, 0, 0, 3, 1);
    step();
    chk("busy3_set", busy_vec[3], 1);

    // x0 destination and x0 writeback leave state untouched
    set_iss(1, 0, 0, 0, 1);
    step();
    chk("x0_issue_busy", busy_vec, 32'h8);
    set_iss(0, 0, 0, 0, 0);
    set_req(0, 0, 64'hFF);
    #1 chk("x0_req_ready", bus.req_ready, 2'b01);
    step();
    chk("x0_wen", bus.rf_wen, 0);
    step();
    chk("x0_err", err_sticky, 0);

    // RAW stall until the cycle after the write
    set_iss(1, 3, 0, 0, 0);
    #1 chk("raw_stall", bus.iss_ready, 0);
    set_req(1, 3, 64'h1234);
    step();
    chk("raw_wen", bus.rf_wen, 1);
    chk("raw_rd", bus.rf_rd, 3);
    chk("raw_still_stalled", bus.iss_ready, 0);
    step();
    chk("raw_released", bus.iss_ready, 1);
    set_iss(0, 0, 0, 0, 0);
    step();

    // Round-robin with both requesters continuously valid
    for (int i = 1; i <= 4; i++) begin
      set_iss(1, 0, 0, i, 1);
      step();
    end
    set_iss(0, 0, 0, 0, 0);
    set_req(0, 1, 64'h11);
    set_req(1, 2, 64'h22);
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_gnt", bus.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk("rr_wen", bus.rf_wen, 1);
      chk("rr_rd", bus.rf_rd, i + 1);
      if (i < 2) set_req(i % 2, i + 3, 64'(i + 3) << 4);
    end
    step();
    chk("rr_busy_clear", busy_vec[4:1], 0);

    // Spurious writeback to a non-busy register
    set_req(1, 9, 64'h99);
    step();
    chk("spur_wen", bus.rf_wen, 1);
    chk("spur_rd", bus.rf_rd, 9);
    step();
    chk("spur_err", err_sticky, 1);

    // Same-edge set and clear of register 7
    set_req(0, 7, 64'h77);
    step();
    set_iss(1, 0, 0, 7, 1);
    #1 chk("same_edge_ready", bus.iss_ready, 1);
    step();
    chk("same_edge_busy7", busy_vec[7], 1);
    set_iss(0, 0, 0, 0, 0);
    step();
    chk("same_edge_busy7_hold", busy_vec[7], 1);
    chk("err_held", err_sticky, 1);

    // Reset in the cycle the write would appear
    set_req(0, 5, 64'hAA);
    step();
    do_reset();
    for (int i = 0; i < 3; i++) step();
    chk("post_rst_busy", busy_vec, 0);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      set_iss($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 1));
      for (int i = 0; i < NR; i++) begin
        if (!p_valid[i] && $urandom_range(0, 2) == 0) begin
          busy_list.delete();
          for (int r = 1; r < NREG; r++) if (m_busy[r]) busy_list.push_back(r);
          if (busy_list.size() > 0 && $urandom_range(0, 7) != 0)
            set_req(i, busy_list[$urandom_range(0, busy_list.size() - 1)], {$urandom, $urandom});
          else
            set_req(i, $urandom_range(0, 7), {$urandom, $urandom});
        end
      end
      step();
    end

    // Drain outstanding requests
    set_iss(0, 0, 0, 0, 0);
    for (int n = 0; n < 20; n++) begin
      if (p_valid[0] || p_valid[1]) step();
    end
    chk("drain_requests", {p_valid[0], p_valid[1]}, 0);
    step();
    step();
    chk("drain_queue", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_scoreboard.md
Name: rf_wb_scoreboard

Overview:
- Controls the register file's single write port.
- Arbitrates writeback requests from NREQ producers (e.g. ALU, LSU, CSR unit) onto that port with round-robin fairness.
- Keeps a per-register busy scoreboard so decode stalls on RAW/WAW hazards against in-flight destinations.
- Sits between decode/issue, the execution units and the register file write side (wen/rd/dataD).

Parameters:
- ADDR_WIDTH, 5, register index width; the file has 2^ADDR_WIDTH entries.
- DATA_WIDTH, 64, register data width.
- NREQ, 2, number of writeback requesters (>=2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- iss_valid  in  1  decode presents an instruction for issue.
- iss_rs1  in  ADDR_WIDTH  source register 1 index.
- iss_rs2  in  ADDR_WIDTH  source register 2 index.
- iss_rd  in  ADDR_WIDTH  destination index.
- iss_wr  in  1  instruction writes iss_rd.
- iss_ready  out  1  issue permitted (no hazard); combinational.
- req_valid  in  NREQ  writeback request per producer.
- req_rd  in  NREQ*ADDR_WIDTH  packed destination indices; requester i at slice i.
- req_data  in  NREQ*DATA_WIDTH  packed writeback data.
- req_ready  out  NREQ  one-hot grant; combinational.
- rf_wen  out  1  register file write enable; registered.
- rf_rd  out  ADDR_WIDTH  register file write index; registered.
- rf_dataD  out  DATA_WIDTH  register file write data; registered.
- busy_vec  out  2^ADDR_WIDTH  scoreboard state, for debug.
- err_sticky  out  1  set by a writeback to a non-busy register; cleared only by reset.

Behaviour:
- Reset (asynchronous, whenever rst=1):
  - rf_wen=0, rf_rd=0, rf_dataD=0.
  - busy_vec all 0, err_sticky=0.
  - Round-robin pointer=0.
  - Any in-flight write is dropped.
- Arbitration:
  - Search starts at the pointer and moves upward, wrapping modulo NREQ. The first requester with req_valid=1 gets req_ready=1; all others get 0.
  - At most one grant per cycle.
  - On a grant to requester g, the pointer becomes (g+1) mod NREQ at the next edge. With no grant, the pointer holds.
  - Handshake = req_valid & req_ready. A requester holds valid, rd and data stable until granted.
- Write port latency:
  - A handshake in cycle t gives rf_wen=1, rf_rd=req_rd[g], rf_dataD=req_data[g] in cycle t+1. The register file commits at the end of t+1.
  - With no handshake in t, rf_wen=0 in t+1 and rf_rd/rf_dataD hold their old values.
  - Back-to-back handshakes give rf_wen=1 on consecutive cycles (sustained one write per cycle).
- x0 handling:
  - A handshake with rd=0 completes normally but rf_wen stays 0.
  - busy[0] is hardwired to 0.
- Scoreboard:
  - Set: an issue handshake (iss_valid & iss_ready & iss_wr) with iss_rd != 0 sets busy[iss_rd] at the edge.
  - Clear: the edge that ends a cycle with rf_wen=1 clears busy[rf_rd]. Consequence: the first cycle busy reads 0, the register file already holds the value.
  - Set and clear of the same index on the same edge: set wins, so the register stays busy for the new writer.
  - Writeback handshake to a register with busy=0 (rd != 0): the write still happens and err_sticky is set.
- Hazard check:
  - iss_ready = ~(busy[iss_rs1] | busy[iss_rs2] | (iss_wr & busy[iss_rd])).
  - iss_ready is independent of iss_valid.
  - busy[0]=0, so x0 operands never stall.
  - No bypassing; the stall lasts until the clear edge described above.

Decomposition:
- Shared package:
  - Default ADDR_WIDTH/DATA_WIDTH constants.
  - Register count localparam (1<<ADDR_WIDTH).
  - The x0 index constant.
- Natural sub-module: rr_arbiter, a parameterized NREQ round-robin one-hot arbiter with its own pointer register.
- Scoreboard, write register and hazard logic stay in the top level.

Test Plan:
- Reset mid-write: handshake req0 rd=5 data=0xAA, assert rst in the next cycle → rf_wen=0 immediately, busy_vec=0, and no write appears after rst is released.
- Round-robin: req0 and req1 both held valid for 4 cycles with rd=1..4 → grants alternate 0,1,0,1; rf_wen=1 for 4 consecutive cycles starting one cycle later.
- RAW stall: issue rd=3 (busy[3]=1); then present rs1=3 → iss_ready=0. Writeback rd=3 data=0x1234 in cycle t → rf_wen at t+1; iss_ready=1 from t+2.
- Same-edge set/clear: rf_wen=1 with rf_rd=7 in the same cycle as an issue handshake with rd=7 → busy[7] stays 1 afterwards.
- x0: issue rd=0 → busy_vec unchanged. Writeback rd=0 data=0xFF → req_ready=1, rf_wen stays 0, err_sticky stays 0.
- Spurious writeback: req1 rd=9 with busy[9]=0 → rf_wen=1 with rf_rd=9 next cycle, and err_sticky=1 until reset.
